// File: rtl/control_decode_pkg.sv
// Shared types for the RV32 decode queue: the packed control word, opcode map,
// ALU/operand/writeback selectors and the serialisation predicate.
package control_decode_pkg;

  localparam logic [31:0] HALT_INSN = 32'hFFFF_FFFF;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} alu_a_sel_t;
  typedef enum logic       {B_RS2, B_IMM} alu_b_sel_t;
  typedef enum logic [1:0] {W_ALU, W_MEM, W_PC4, W_CSR} w_sel_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        imm_shamt_sel;
    logic [4:0]  shamt;
    alu_op_t     alu_op;
    alu_a_sel_t  alu_a_sel;
    alu_b_sel_t  alu_b_sel;
    w_sel_t      w_sel;
    logic [2:0]  load_type;
    logic [2:0]  branch_type;
    logic        dwen;
    logic        dren;
    logic        wen;
    logic        branch;
    logic        jump;
    logic        j_sel;
    logic        csr_swap;
    logic        csr_set;
    logic        csr_clr;
    logic        csr_imm;
    logic        csr_rw_valid;
    logic [11:0] csr_addr;
    logic [4:0]  zimm;
    logic        ret_insn;
    logic        ecall_insn;
    logic        breakpoint;
    logic        ifence;
    logic        illegal_insn;
    logic        halt;
    logic        serial;
    logic        fpu_en;
    logic [4:0]  fpu_op;
    logic        f_wen;
    logic        f_load;
    logic        f_store;
  } ctrl_word_t;

  // alt selects SUB/SRA, driven by instr[30] where the encoding allows it.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic is_serial(input ctrl_word_t c);
    return c.csr_swap | c.csr_set | c.csr_clr | c.ecall_insn | c.breakpoint |
           c.ret_insn | c.ifence | c.illegal_insn | c.halt;
  endfunction

endpackage

// File: rtl/rv32_ctrl_decoder.sv
// Combinational RV32I (+ optional F load/store/op) decoder producing one ctrl_word_t
// per instruction word; side effects are suppressed for illegal encodings.
module rv32_ctrl_decoder
  import control_decode_pkg::*;
#(
  parameter bit ENABLE_FPU = 1'b0
) (
  input  logic [31:0] instr,
  output ctrl_word_t  ctrl
);

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    // NOTE: the whole word is defaulted before the case so no field is left unassigned on any path (no latches).
    ctrl        = '0;
    ctrl.opcode = instr[6:0];
    ctrl.rd     = instr[11:7];
    ctrl.rs1    = instr[19:15];
    ctrl.rs2    = instr[24:20];
    ctrl.shamt  = instr[24:20];
    ctrl.zimm   = instr[19:15];

    case (instr[6:0])
      OPC_LUI: begin
        ctrl.imm = imm_u; ctrl.alu_a_sel = A_ZERO; ctrl.alu_b_sel = B_IMM; ctrl.wen = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.imm = imm_u; ctrl.alu_a_sel = A_PC; ctrl.alu_b_sel = B_IMM; ctrl.wen = 1'b1;
      end
      OPC_JAL: begin
        ctrl.imm = imm_j; ctrl.jump = 1'b1; ctrl.wen = 1'b1; ctrl.w_sel = W_PC4;
        ctrl.alu_a_sel = A_PC; ctrl.alu_b_sel = B_IMM;
      end
      OPC_JALR: begin
        ctrl.imm = imm_i; ctrl.jump = 1'b1; ctrl.j_sel = 1'b1; ctrl.wen = 1'b1;
        ctrl.w_sel = W_PC4; ctrl.alu_b_sel = B_IMM;
        ctrl.illegal_insn = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl.imm = imm_b; ctrl.branch = 1'b1; ctrl.branch_type = funct3; ctrl.alu_op = ALU_SUB;
        ctrl.illegal_insn = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        ctrl.imm = imm_i; ctrl.dren = 1'b1; ctrl.wen = 1'b1; ctrl.w_sel = W_MEM;
        ctrl.alu_b_sel = B_IMM; ctrl.load_type = funct3;
        ctrl.illegal_insn = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        ctrl.imm = imm_s; ctrl.dwen = 1'b1; ctrl.alu_b_sel = B_IMM; ctrl.load_type = funct3;
        ctrl.illegal_insn = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_OP_IMM: begin
        ctrl.imm = imm_i; ctrl.alu_b_sel = B_IMM; ctrl.wen = 1'b1;
        ctrl.alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && instr[30]);
        if (funct3[1:0] == 2'b01) begin
          ctrl.imm_shamt_sel = 1'b1;
          ctrl.illegal_insn  = (funct7 != 7'b0) && !((funct3 == 3'b101) && (funct7 == 7'b0100000));
        end
      end
      OPC_OP: begin
        ctrl.wen    = 1'b1;
        ctrl.alu_op = alu_from_funct3(funct3, instr[30]);
        ctrl.illegal_insn = !((funct7 == 7'b0) ||
                              ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_MISC_MEM: begin
        ctrl.ifence       = (funct3 == 3'b001);
        ctrl.illegal_insn = (funct3[2:1] != 2'b00);
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) begin
          if (instr[19:7] != '0) ctrl.illegal_insn = 1'b1;
          else begin
            case (instr[31:20])
              12'h000:          ctrl.ecall_insn   = 1'b1;
              12'h001:          ctrl.breakpoint   = 1'b1;
              12'h102, 12'h302: ctrl.ret_insn     = 1'b1;
              default:          ctrl.illegal_insn = 1'b1;
            endcase
          end
        end else if (funct3 == 3'b100) begin
          ctrl.illegal_insn = 1'b1;
        end else begin
          ctrl.csr_swap     = (funct3[1:0] == 2'b01);
          ctrl.csr_set      = (funct3[1:0] == 2'b10);
          ctrl.csr_clr      = (funct3[1:0] == 2'b11);
          ctrl.csr_imm      = funct3[2];
          ctrl.csr_addr     = instr[31:20];
          ctrl.csr_rw_valid = ctrl.csr_swap || (ctrl.zimm != '0);
          ctrl.w_sel        = W_CSR;
          ctrl.wen          = 1'b1;
        end
      end
      OPC_LOAD_FP: begin
        if (ENABLE_FPU && (funct3 == 3'b010)) begin
          ctrl.imm = imm_i; ctrl.dren = 1'b1; ctrl.f_load = 1'b1; ctrl.f_wen = 1'b1;
          ctrl.alu_b_sel = B_IMM; ctrl.w_sel = W_MEM;
        end else ctrl.illegal_insn = 1'b1;
      end
      OPC_STORE_FP: begin
        if (ENABLE_FPU && (funct3 == 3'b010)) begin
          ctrl.imm = imm_s; ctrl.dwen = 1'b1; ctrl.f_store = 1'b1; ctrl.alu_b_sel = B_IMM;
        end else ctrl.illegal_insn = 1'b1;
      end
      OPC_OP_FP: begin
        if (ENABLE_FPU) begin
          ctrl.fpu_en = 1'b1; ctrl.fpu_op = instr[31:27]; ctrl.f_wen = 1'b1;
        end else ctrl.illegal_insn = 1'b1;
      end
      default: ctrl.illegal_insn = 1'b1;
    endcase

    // An illegal word must not write state; it only traps once it reaches execute.
    if (ctrl.illegal_insn) begin
      ctrl.wen = 1'b0; ctrl.dwen = 1'b0; ctrl.dren = 1'b0; ctrl.f_wen = 1'b0;
      ctrl.branch = 1'b0; ctrl.jump = 1'b0; ctrl.csr_rw_valid = 1'b0;
    end
    if (ctrl.rd == '0) ctrl.wen = 1'b0;
    ctrl.halt   = (instr == HALT_INSN);
    ctrl.serial = is_serial(ctrl);
  end

endmodule

// File: rtl/control_decode_queue.sv
// Decode-and-buffer stage between fetch and execute: decodes on enqueue, holds up to
// DEPTH entries, and stalls fetch while a serialising instruction is in flight.
module control_decode_queue
  import control_decode_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  bit ENABLE_FPU = 1'b0,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output ctrl_word_t       out_ctrl,
  output logic [CNT_W-1:0] occupancy,
  output logic             serial_pending
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  ctrl_word_t       dec_ctrl;
  ctrl_word_t       ctrl_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             serial_q;
  logic             enq, deq;

  rv32_ctrl_decoder #(.ENABLE_FPU(ENABLE_FPU)) u_decoder (
    .instr (in_instr),
    .ctrl  (dec_ctrl)
  );

  // Ready never looks at out_ready, so there is no combinational path fetch <-> execute.
  assign in_ready       = (count < FULL_CNT) && !serial_q && !flush;
  assign out_valid      = (count != '0);
  assign enq            = in_valid && in_ready;
  assign deq            = out_valid && out_ready;
  assign out_ctrl       = ctrl_mem[rd_ptr];
  assign out_pc         = pc_mem[rd_ptr];
  assign occupancy      = count;
  assign serial_pending = serial_q;

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!nRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      serial_q <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      serial_q <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      // At most one serialising entry can be queued, so its departure always clears the block.
      if (deq && out_ctrl.serial)      serial_q <= 1'b0;
      else if (enq && dec_ctrl.serial) serial_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: the array is reset because the head is read straight out of it and must show zero out of reset.
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (enq) begin
      ctrl_mem[wr_ptr] <= dec_ctrl;
      pc_mem[wr_ptr]   <= in_pc;
    end
  end

endmodule

// File: tb/tb_control_decode_queue.sv
// Scoreboard bench: the driver pushes hand-decoded expectations on each accepted
// enqueue; an independent monitor pops and compares whenever the head is consumed.
module tb_control_decode_queue;
  import control_decode_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        wen, ill, ser, halt, swap, rwv, ifence;
    logic [11:0] csr;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } exp_t;

  logic        CLK, nRST, flush, in_valid, in_ready, out_valid, out_ready, serial_pending;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [2:0]  occupancy;
  ctrl_word_t  out_ctrl;

  vec_t vecs [14];
  exp_t sb_q [$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  control_decode_queue #(.DEPTH(4), .ENABLE_FPU(1'b0)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_ctrl       (out_ctrl),
    .occupancy      (occupancy),
    .serial_pending (serial_pending)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] instr, input logic [4:0] rd,
                              input logic [31:0] imm, input logic wen, input logic ill,
                              input logic ser, input logic halt, input logic swap,
                              input logic rwv, input logic [11:0] csr, input logic ifence);
    vec_t v;
    v.name = name; v.instr = instr; v.rd = rd; v.imm = imm; v.wen = wen; v.ill = ill;
    v.ser = ser; v.halt = halt; v.swap = swap; v.rwv = rwv; v.csr = csr; v.ifence = ifence;
    return v;
  endfunction

  task automatic init_vecs();
    //                name      instr          rd  imm            wen ill ser hlt swp rwv csr     ifc
    vecs[0]  = mk("addi5",   32'h00500093,  1, 32'h00000005, 1, 0, 0, 0, 0, 0, 12'h000, 0);
    vecs[1]  = mk("addim1",  32'hFFF00113,  2, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 12'h000, 0);
    vecs[2]  = mk("addi_x0", 32'h00000013,  0, 32'h00000000, 0, 0, 0, 0, 0, 0, 12'h000, 0);
    vecs[3]  = mk("csrrw",   32'h30009073,  0, 32'h00000000, 0, 0, 1, 0, 1, 1, 12'h300, 0);
    vecs[4]  = mk("zero",    32'h00000000,  0, 32'h00000000, 0, 1, 1, 0, 0, 0, 12'h000, 0);
    vecs[5]  = mk("fence_i", 32'h0000100F,  0, 32'h00000000, 0, 0, 1, 0, 0, 0, 12'h000, 1);
    vecs[6]  = mk("flw",     32'h00052007,  0, 32'h00000000, 0, 1, 1, 0, 0, 0, 12'h000, 0);
    vecs[7]  = mk("lui",     32'h123452B7,  5, 32'h12345000, 1, 0, 0, 0, 0, 0, 12'h000, 0);
    vecs[8]  = mk("beq",     32'h00208463,  8, 32'h00000008, 0, 0, 0, 0, 0, 0, 12'h000, 0);
    vecs[9]  = mk("jal",     32'hFFDFF0EF,  1, 32'hFFFFFFFC, 1, 0, 0, 0, 0, 0, 12'h000, 0);
    vecs[10] = mk("sw",      32'hFE20AC23, 24, 32'hFFFFFFF8, 0, 0, 0, 0, 0, 0, 12'h000, 0);
    vecs[11] = mk("mul",     32'h022081B3,  3, 32'h00000000, 0, 1, 1, 0, 0, 0, 12'h000, 0);
    vecs[12] = mk("ones",    32'hFFFFFFFF, 31, 32'h00000000, 0, 1, 1, 1, 0, 0, 12'h000, 0);
    vecs[13] = mk("csrrs0",  32'h300022F3,  5, 32'h00000000, 1, 0, 1, 0, 0, 0, 12'h300, 0);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send(input int idx, input logic [31:0] pc);
    exp_t e;
    bit   done;
    done = 1'b0;
    in_valid = 1'b1; in_instr = vecs[idx].instr; in_pc = pc;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge CLK);
      if (in_ready) begin
        e.v = vecs[idx]; e.pc = pc;
        sb_q.push_back(e);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    check($sformatf("%s.accepted", vecs[idx].name), done, 1);
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && !empty; c++) begin
      @(negedge CLK);
      if (occupancy == 0) empty = 1'b1;
      else tick();
    end
    out_ready = 1'b0;
    check("drain.empty", empty, 1);
    tick();
  endtask

  task automatic compare(input exp_t e);
    check($sformatf("%s.pc", e.v.name),      out_pc,                e.pc);
    check($sformatf("%s.rd", e.v.name),      out_ctrl.rd,           e.v.rd);
    check($sformatf("%s.imm", e.v.name),     out_ctrl.imm,          e.v.imm);
    check($sformatf("%s.wen", e.v.name),     out_ctrl.wen,          e.v.wen);
    check($sformatf("%s.illegal", e.v.name), out_ctrl.illegal_insn, e.v.ill);
    check($sformatf("%s.serial", e.v.name),  out_ctrl.serial,       e.v.ser);
    check($sformatf("%s.halt", e.v.name),    out_ctrl.halt,         e.v.halt);
    check($sformatf("%s.csr_swap", e.v.name), out_ctrl.csr_swap,    e.v.swap);
    check($sformatf("%s.csr_rwv", e.v.name), out_ctrl.csr_rw_valid, e.v.rwv);
    check($sformatf("%s.csr_addr", e.v.name), out_ctrl.csr_addr,    e.v.csr);
    check($sformatf("%s.ifence", e.v.name),  out_ctrl.ifence,       e.v.ifence);
  endtask

  // Monitor: a head seen with out_ready high at the falling edge leaves at the next rising edge.
  always @(negedge CLK) begin
    if (!nRST || flush) sb_q.delete();
    else if (out_valid && out_ready) begin
      check("sb.nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        compare(mon_e);
      end
    end
  end

  initial begin
    init_vecs();
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #12;
    check("rst.out_valid", out_valid, 0);
    check("rst.occupancy", occupancy, 0);
    check("rst.serial", serial_pending, 0);
    check("rst.out_pc", out_pc, 0);
    check("rst.out_ctrl_zero", out_ctrl == '0, 1);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("post_rst.in_ready", in_ready, 1);
    tick();

    // Single enqueue, held at the head.
    send(0, 32'h100);
    @(negedge CLK);
    check("t1.out_valid", out_valid, 1);
    check("t1.occupancy", occupancy, 1);
    tick();

    // Sign-extended immediate and rd=x0, then in-order drain.
    send(1, 32'h104);
    send(2, 32'h108);
    @(negedge CLK);
    check("t2.occupancy", occupancy, 3);
    tick();
    drain();

    // Fill to DEPTH, free one slot while fetch keeps offering.
    send(7, 32'h200);
    send(8, 32'h204);
    send(9, 32'h208);
    send(10, 32'h20C);
    @(negedge CLK);
    check("t3.full_occ", occupancy, 4);
    check("t3.full_in_ready", in_ready, 0);
    tick();
    fork
      send(1, 32'h210);
      begin
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge CLK);
        check("t3.occ_after_pop", occupancy, 3);
        check("t3.in_ready_after_pop", in_ready, 1);
      end
    join
    @(negedge CLK);
    check("t3.refilled_occ", occupancy, 4);
    tick();
    drain();

    // CSR write serialises fetch until it leaves.
    send(3, 32'h300);
    @(negedge CLK);
    check("t4.serial_pending", serial_pending, 1);
    check("t4.in_ready_blocked", in_ready, 0);
    tick();
    in_valid = 1'b1; in_instr = vecs[0].instr; in_pc = 32'h304;
    tick();
    tick();
    @(negedge CLK);
    check("t4.occ_held", occupancy, 1);
    check("t4.still_blocked", in_ready, 0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge CLK);
    check("t4.serial_cleared", serial_pending, 0);
    check("t4.in_ready_resumed", in_ready, 1);
    check("t4.occ_empty", occupancy, 0);
    tick();

    // Flush beats a concurrent enqueue and dequeue and clears the serial block.
    send(0, 32'h400);
    send(1, 32'h404);
    send(4, 32'h408);
    @(negedge CLK);
    check("t5.occ_before", occupancy, 3);
    check("t5.serial_before", serial_pending, 1);
    tick();
    flush = 1'b1; in_valid = 1'b1; in_instr = vecs[7].instr; in_pc = 32'h40C; out_ready = 1'b1;
    @(negedge CLK);
    check("t5.in_ready_flush", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge CLK);
    check("t5.occ_after", occupancy, 0);
    check("t5.out_valid_after", out_valid, 0);
    check("t5.serial_after", serial_pending, 0);
    check("t5.in_ready_after", in_ready, 1);
    tick();

    // Streaming mix of illegal, serialising and branch/jump/store encodings.
    out_ready = 1'b1;
    send(4, 32'h500);
    send(5, 32'h504);
    send(6, 32'h508);
    send(11, 32'h50C);
    send(12, 32'h510);
    send(13, 32'h514);
    send(9, 32'h518);
    drain();

    // Asynchronous reset in the middle of the stream.
    send(0, 32'h600);
    send(7, 32'h604);
    #2;
    nRST = 1'b0;
    #1;
    check("t6.rst_out_valid", out_valid, 0);
    check("t6.rst_occupancy", occupancy, 0);
    check("t6.rst_serial", serial_pending, 0);
    check("t6.rst_out_pc", out_pc, 0);
    check("t6.rst_out_ctrl_zero", out_ctrl == '0, 1);
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    check("t6.post_rst_in_ready", in_ready, 1);
    check("t6.post_rst_out_valid", out_valid, 0);
    check("sb.final_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
